bdl_desc_fifo: RTL and testbench

- Parametrised successor to the single-descriptor BDL register set.
- Holds up to DEPTH complete buffer descriptors of WORDS words each, arranged as a circular queue.
- Producer side: the BDL fetch sequencer loads descriptors word-serially with an auto-incrementing word pointer; each descriptor is committed atomically after its last word.
- Consumer side: the transmit/receive DMA engine reads the head descriptor at random word index, writes status words back into it, then pops it.

---
 rtl/bdl_pkg.sv | 24 ++
 rtl/bdl_desc_ram.sv | 50 +++++
 rtl/bdl_desc_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_bdl_desc_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdl_pkg.sv
// ----------------------------------------------------------------------------
// bdl_pkg
// Shared constants for the buffer-descriptor list (BDL) descriptor FIFO.
// Defines the default descriptor length, the word layout inside one
// descriptor and the "unused slot" flag pattern.
// No ports (package).
// ----------------------------------------------------------------------------
package bdl_pkg;

    // Words per buffer descriptor.
    localparam int DESC_WORDS = 6;

    // Word layout of one descriptor.
    localparam int W_FLAG  = 0;
    localparam int W_ADDRH = 1;
    localparam int W_ADDRL = 2;
    localparam int W_LEN   = 3;
    localparam int W_ST1   = 4;
    localparam int W_ST2   = 5;

    // Flag word value marking a descriptor slot as unused.
    localparam logic [15:0] FLAG_UNUSED = 16'hFFFF;

endpackage : bdl_pkg

// File: rtl/bdl_desc_ram.sv
// ----------------------------------------------------------------------------
// bdl_desc_ram
// Descriptor storage: flat DEPTH*WORDS x DW array addressed by
// {slot, word}, flattened as slot*WORDS + word so no addresses are wasted
// when WORDS is not a power of two.
// Ports:
//   clk                      write clock
//   we, wr_slot, wr_word,    synchronous write port
//   wr_data
//   rd_slot, rd_word         asynchronous read address
//   rd_data                  asynchronous read data
// ----------------------------------------------------------------------------
module bdl_desc_ram #(
    parameter  int DEPTH = 4,
    parameter  int WORDS = 6,
    parameter  int DW    = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int WI    = $clog2(WORDS),
    localparam int AD    = $clog2(DEPTH * WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_slot,
    input  logic [WI-1:0] wr_word,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_slot,
    input  logic [WI-1:0] rd_word,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH*WORDS];

    function automatic logic [AD-1:0] flat_addr(input logic [AW-1:0] slot,
                                                input logic [WI-1:0] word);
        return AD'(int'(slot) * WORDS + int'(word));
    endfunction

    // NOTE: storage carries no reset; a memory array with a reset cannot map
    // onto RAM primitives, and the queue pointers already mark every slot
    // as invalid after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[flat_addr(wr_slot, wr_word)] <= wr_data;
        end
    end

    // Out-of-range word indices are masked to zero by the caller.
    assign rd_data = mem[flat_addr(rd_slot, rd_word)];

endmodule : bdl_desc_ram

// File: rtl/bdl_desc_fifo.sv
// ----------------------------------------------------------------------------
// bdl_desc_fifo
// Circular queue of DEPTH buffer descriptors, WORDS words each.
// The fetch sequencer loads descriptors word-serially at the tail; a
// descriptor becomes visible only once its last word is written. The DMA
// engine reads the head descriptor at any word index, writes status back
// into it and pops it.
//
// Optional feature macro: BDL_DESC_ERR_EN (sticky overflow/underflow flags).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en, wr_data, wr_abort  producer word push / discard partial descriptor
//   wr_idx                    index of the next word to be written
//   full, empty, count        occupancy of committed descriptors
//   rd_word, rd_data          combinational head-descriptor read
//   st_we, st_word, st_data   status write-back into the head descriptor
//   pop                       release the head descriptor
//   err_ovf, err_udf, err_clr sticky error flags and their clear
// ----------------------------------------------------------------------------
module bdl_desc_fifo
    import bdl_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WORDS = DESC_WORDS,
    parameter  int DW    = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int WI    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_abort,
    output logic [WI-1:0] wr_idx,
    output logic          full,
    input  logic [WI-1:0] rd_word,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic [AW:0]   count,
    input  logic          st_we,
    input  logic [WI-1:0] st_word,
    input  logic [DW-1:0] st_data,
    input  logic          pop,
    output logic          err_ovf,
    output logic          err_udf,
    input  logic          err_clr
);

    // Fill FSM: IDLE means no partial descriptor is pending (wr_idx == 0).
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [AW-1:0] head_q,   head_d;
    logic [AW-1:0] tail_q,   tail_d;
    logic [AW:0]   count_q,  count_d;
    logic [WI-1:0] wr_idx_q, wr_idx_d;
    logic [0:0]    state_q,  state_d;

    logic          fill_we;
    logic          last_word;
    logic          commit;
    logic          pop_ok;
    logic          st_ok;

    logic          ram_we;
    logic [AW-1:0] ram_slot;
    logic [WI-1:0] ram_word;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign count  = count_q;
    assign wr_idx = wr_idx_q;

    assign fill_we   = wr_en & ~full & ~wr_abort;
    assign last_word = (wr_idx_q == WI'(WORDS - 1));
    // WORDS >= 2, so the last word is always written from the FILL state.
    assign commit    = fill_we & (state_q == ST_FILL) & last_word;
    assign pop_ok    = pop & ~empty;
    assign st_ok     = st_we & ~empty & (int'(st_word) < WORDS);

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_idx_d = wr_idx_q;
        state_d  = state_q;

        if (wr_abort) begin
            // Abort beats a same-cycle wr_en: the partial descriptor and
            // the word offered this cycle are both dropped.
            wr_idx_d = '0;
            state_d  = ST_IDLE;
        end else if (fill_we) begin
            if (commit) begin
                wr_idx_d = '0;
                state_d  = ST_IDLE;
                tail_d   = tail_q + 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
                state_d  = ST_FILL;
            end
        end

        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end

        // Commit and pop in the same cycle leave the count unchanged.
        case ({commit, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_idx_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_idx_q <= wr_idx_d;
            state_q  <= state_d;
        end
    end

    // Single storage write port shared by fill and status write-back. The
    // fetch sequencer and the DMA engine are not expected to write in the
    // same cycle; if they do, the fill word takes the port.
    assign ram_we    = fill_we | st_ok;
    assign ram_slot  = fill_we ? tail_q   : head_q;
    assign ram_word  = fill_we ? wr_idx_q : st_word;
    assign ram_wdata = fill_we ? wr_data  : st_data;

    bdl_desc_ram #(
        .DEPTH (DEPTH),
        .WORDS (WORDS),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_slot (ram_slot),
        .wr_word (ram_word),
        .wr_data (ram_wdata),
        .rd_slot (head_q),
        .rd_word (rd_word),
        .rd_data (ram_rdata)
    );

    assign rd_data = (~empty && (int'(rd_word) < WORDS)) ? ram_rdata : '0;

`ifdef BDL_DESC_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;
    logic ovf_set,   udf_set;

    assign ovf_set = wr_en & full & ~wr_abort;
    assign udf_set = (pop | st_we) & empty;

    // A set event in the same cycle wins over err_clr.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end
        if (ovf_set) err_ovf_d = 1'b1;
        if (udf_set) err_udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf        = 1'b0;
    assign err_udf        = 1'b0;
`endif

endmodule : bdl_desc_fifo

// File: tb/tb_bdl_desc_fifo.sv
// ----------------------------------------------------------------------------
// tb_bdl_desc_fifo
// Self-checking bench for bdl_desc_fifo. A queue-of-descriptors model tracks
// what the FIFO must hold; a compare process checks every output on every
// falling edge, and directed sequences pin the model with literal values.
// ----------------------------------------------------------------------------
module tb_bdl_desc_fifo;
    import bdl_pkg::*;

    localparam int DEPTH = 4;
    localparam int WORDS = DESC_WORDS;
    localparam int DW    = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int WI    = $clog2(WORDS);

`ifdef BDL_DESC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_abort;
    logic [WI-1:0] wr_idx;
    logic          full;
    logic [WI-1:0] rd_word;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [AW:0]   count;
    logic          st_we;
    logic [WI-1:0] st_word;
    logic [DW-1:0] st_data;
    logic          pop;
    logic          err_ovf;
    logic          err_udf;
    logic          err_clr;

    bdl_desc_fifo #(.DEPTH(DEPTH), .WORDS(WORDS), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_abort (wr_abort),
        .wr_idx   (wr_idx),
        .full     (full),
        .rd_word  (rd_word),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
        .st_we    (st_we),
        .st_word  (st_word),
        .st_data  (st_data),
        .pop      (pop),
        .err_ovf  (err_ovf),
        .err_udf  (err_udf),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Model: committed descriptors in order (index 0 = head), plus the
    // descriptor being assembled.
    logic [WORDS*DW-1:0] mq[$];
    logic [WORDS*DW-1:0] pbuf;
    int                  pidx;
    bit                  m_ovf;
    bit                  m_udf;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd();
        logic [WORDS*DW-1:0] t;
        if (mq.size() == 0 || int'(rd_word) >= WORDS) return '0;
        t = mq[0];
        return t[int'(rd_word)*DW +: DW];
    endfunction

    // Applies one clock edge's worth of the behavioural rules, using the
    // inputs that were held across that edge.
    task automatic model_update();
        logic [WORDS*DW-1:0] t;
        bit m_empty, m_full;
        if (rst) begin
            mq.delete();
            pidx  = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == DEPTH);
        if (ERR_EN) begin
            if (err_clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wr_en && m_full && !wr_abort) m_ovf = 1'b1;
            if ((pop || st_we) && m_empty)    m_udf = 1'b1;
        end
        if (st_we && !m_empty && int'(st_word) < WORDS) begin
            t = mq[0];
            t[int'(st_word)*DW +: DW] = st_data;
            mq[0] = t;
        end
        if (pop && !m_empty) void'(mq.pop_front());
        if (wr_abort) begin
            pidx = 0;
        end else if (wr_en && !m_full) begin
            pbuf[pidx*DW +: DW] = wr_data;
            pidx++;
            if (pidx == WORDS) begin
                mq.push_back(pbuf);
                pidx = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wr_idx",  32'(wr_idx),  32'(pidx));
            check("count",   32'(count),   32'(mq.size()));
            check("empty",   32'(empty),   32'(mq.size() == 0));
            check("full",    32'(full),    32'(mq.size() == DEPTH));
            check("rd_data", 32'(rd_data), 32'(exp_rd()));
            check("err_ovf", 32'(err_ovf), 32'(m_ovf));
            check("err_udf", 32'(err_udf), 32'(m_udf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_abort = 1'b0;
        rd_word = '0; st_we = 1'b0; st_word = '0; st_data = '0;
        pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_desc(input logic [DW-1:0] base);
        for (int w = 0; w < WORDS; w++) push_word(base + DW'(w));
    endtask

    task automatic read_check(input string name, input int word,
                              input logic [DW-1:0] exp);
        rd_word = WI'(word);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);

        // 1: six words, wr_idx steps then commit.
        for (int w = 0; w < WORDS; w++) begin
            push_word(DW'(w + 1));
            check("t1_wr_idx", 32'(wr_idx), 32'((w + 1) % WORDS));
        end
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        read_check("t1_rd3", W_LEN, 16'h0004);

        // 2: partial descriptor aborted, then a full one.
        do_reset();
        for (int w = 0; w < 3; w++) push_word(16'h0011 + DW'(w));
        check("t2_partial_empty", 32'(empty), 32'd1);
        wr_abort = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD;
        tick();
        wr_abort = 1'b0; wr_en = 1'b0;
        check("t2_abort_idx", 32'(wr_idx), 32'd0);
        push_desc(16'h00A0);
        check("t2_count", 32'(count), 32'd1);
        read_check("t2_rd0", W_FLAG, 16'h00A0);

        // 3: fill to full, overflow attempt, pop.
        do_reset();
        for (int d = 0; d < DEPTH; d++) push_desc(DW'(16'h0100 * (d + 1)));
        check("t3_full", 32'(full), 32'd1);
        push_word(FLAG_UNUSED);
        check("t3_ovf_idx",   32'(wr_idx),  32'd0);
        check("t3_ovf_count", 32'(count),   32'd4);
        check("t3_err_ovf",   32'(err_ovf), 32'(ERR_EN));
        pop = 1'b1; tick(); pop = 1'b0;
        check("t3_pop_count", 32'(count), 32'd3);
        check("t3_pop_full",  32'(full),  32'd0);

        // 4: status write with pop, then refill the freed slots.
        st_we = 1'b1; st_word = WI'(W_ST1); st_data = 16'h2000; pop = 1'b1;
        tick();
        st_we = 1'b0; pop = 1'b0;
        check("t4_count", 32'(count), 32'd2);
        read_check("t4_head", W_FLAG, 16'h0300);
        push_desc(16'h00B0);
        push_desc(16'h00C0);
        check("t4_full", 32'(full), 32'd1);
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1; tick(); pop = 1'b0;
        end
        check("t4_count1", 32'(count), 32'd1);
        read_check("t4_st1", W_ST1, 16'h00C4);

        // 5: commit and pop in the same cycle at count 2.
        do_reset();
        push_desc(16'h0010);
        push_desc(16'h0020);
        for (int w = 0; w < WORDS - 1; w++) push_word(16'h0030 + DW'(w));
        pop = 1'b1;
        push_word(16'h0035);
        pop = 1'b0;
        check("t5_count", 32'(count), 32'd2);
        read_check("t5_head", W_FLAG, 16'h0020);

        // 6: underflow, clear, reset mid-fill.
        do_reset();
        pop = 1'b1; st_we = 1'b1; st_word = WI'(W_ST2); st_data = 16'h5555;
        tick();
        pop = 1'b0; st_we = 1'b0;
        check("t6_count",   32'(count),   32'd0);
        check("t6_empty",   32'(empty),   32'd1);
        check("t6_err_udf", 32'(err_udf), 32'(ERR_EN));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t6_clr_udf", 32'(err_udf), 32'd0);
        push_word(16'h0077);
        push_word(16'h0078);
        check("t6_mid_idx", 32'(wr_idx), 32'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_idx",   32'(wr_idx), 32'd0);
        check("t6_rst_empty", 32'(empty),  32'd1);

        // Random traffic; the compare process checks every cycle.
        for (int seg = 0; seg < 20; seg++) begin
            int pop_pct;
            pop_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                rst      = ($urandom_range(0, 999) == 0);
                wr_en    = ($urandom_range(0, 99) < 70);
                wr_data  = 16'($urandom);
                wr_abort = ($urandom_range(0, 39) == 0);
                pop      = ($urandom_range(0, 99) < pop_pct);
                st_we    = !wr_en && ($urandom_range(0, 99) < 40);
                st_word  = 3'($urandom_range(0, 7));
                st_data  = 16'($urandom);
                rd_word  = 3'($urandom_range(0, 7));
                err_clr  = ($urandom_range(0, 29) == 0);
                tick();
            end
        end
        idle_inputs();
        tick();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bdl_desc_fifo
